// File: rtl/mux_stream_pkg.sv
// rtl/mux_stream_pkg.sv - shared state and mode definitions for mux_stream
package mux_stream_pkg;

  typedef enum logic {
    IDLE   = 1'b0,
    LOCKED = 1'b1
  } state_t;

  localparam logic MODE_SEL = 1'b0;
  localparam logic MODE_RR  = 1'b1;

endpackage

// File: rtl/mux_stream_arbiter.sv
// rtl/mux_stream_arbiter.sv - combinational round-robin search for mux_stream
module rr_arbiter
  import mux_stream_pkg::*;
#(
  parameter  int N    = 4,
  localparam int SELW = $clog2(N)
) (
  input  logic [N-1:0]    req,
  input  logic [SELW-1:0] last_grant,
  output logic [SELW-1:0] grant_idx,
  output logic            grant_vld
);

  int c;

  // first requester strictly after last_grant, wrapping so last_grant itself is checked last
  always_comb begin
    grant_idx = '0;
    grant_vld = 1'b0;
    c         = 0;
    for (int i = 1; i <= N; i++) begin
      c = (int'(last_grant) + i) % N;
      if (!grant_vld && req[c]) begin
        grant_vld = 1'b1;
        grant_idx = c[SELW-1:0];
      end
    end
  end

endmodule

// File: rtl/mux_stream.sv
// rtl/mux_stream.sv - N-channel packet-locking stream mux with registered output
module mux_stream
  import mux_stream_pkg::*;
#(
  parameter  int WIDTH = 8,
  parameter  int N     = 4,
  localparam int SELW  = $clog2(N)
) (
  input  logic                 clk,
  input  logic                 rst,
  input  logic                 mode,
  input  logic [SELW-1:0]      sel,
  input  logic [N*WIDTH-1:0]   in_data,
  input  logic [N-1:0]         in_valid,
  input  logic [N-1:0]         in_last,
  output logic [N-1:0]         in_ready,
  output logic [WIDTH-1:0]     out_data,
  output logic                 out_valid,
  output logic                 out_last,
  input  logic                 out_ready,
  output logic [SELW-1:0]      cur_ch
);

  // select space padded to a power of two so an out-of-range sel reads as "not valid"
  localparam int              SELN    = 1 << SELW;
  localparam logic [SELW-1:0] LAST_CH = SELW'(N - 1);

  state_t           state;
  state_t           state_nxt;
  logic [SELW-1:0]  cur_nxt;
  logic [SELW-1:0]  rr_idx;
  logic             rr_vld;
  logic             slot_free;
  logic             accept;
  logic             grant;
  logic [SELN-1:0]  sel_valid;
  logic [WIDTH-1:0] ch_data [N];

  for (genvar k = 0; k < N; k++) begin : g_unpack
    assign ch_data[k] = in_data[k*WIDTH +: WIDTH];
  end

  rr_arbiter #(.N(N)) u_arb (
    .req        (in_valid),
    .last_grant (cur_ch),
    .grant_idx  (rr_idx),
    .grant_vld  (rr_vld)
  );

  // output register can take a beat when empty or draining this cycle
  assign slot_free = !out_valid || out_ready;

  // arbitration, lock release and per-channel ready
  always_comb begin
    state_nxt = state;
    cur_nxt   = cur_ch;
    in_ready  = '0;
    accept    = 1'b0;
    grant     = 1'b0;
    sel_valid = '0;
    sel_valid[N-1:0] = in_valid;
    case (state)
      IDLE: begin
        if (mode == MODE_RR) begin
          grant = rr_vld;
          if (rr_vld) cur_nxt = rr_idx;
        end else begin
          grant = sel_valid[sel];
          if (grant) cur_nxt = sel;
        end
        if (grant) state_nxt = LOCKED;
      end
      LOCKED: begin
        in_ready[cur_ch] = slot_free;
        accept           = in_valid[cur_ch] && slot_free;
        if (accept && in_last[cur_ch]) state_nxt = IDLE;
      end
      default: state_nxt = IDLE;
    endcase
  end

  // lock state and granted channel
  always_ff @(posedge clk) begin
    if (rst) begin
      state  <= IDLE;
      cur_ch <= LAST_CH;
    end else begin
      state  <= state_nxt;
      cur_ch <= cur_nxt;
    end
  end

  // output stage: a newly accepted beat takes priority over draining
  always_ff @(posedge clk) begin
    if (rst) begin
      out_valid <= 1'b0;
      out_data  <= '0;
      out_last  <= 1'b0;
    end else if (accept) begin
      out_valid <= 1'b1;
      out_data  <= ch_data[cur_ch];
      out_last  <= in_last[cur_ch];
    end else if (out_ready) begin
      out_valid <= 1'b0;
    end
  end

endmodule

// File: tb/tb_mux_stream.sv
// tb/tb_mux_stream.sv - randomized self-checking bench for mux_stream
module tb_mux_stream;

  localparam int W = 8;
  localparam int N = 4;

  logic clk = 1'b0;
  always #5 clk = ~clk;

  logic           rst, mode, out_ready;
  logic [1:0]     sel;
  logic [N*W-1:0] in_data;
  logic [N-1:0]   in_valid, in_last, in_ready;
  logic [W-1:0]   out_data;
  logic           out_valid, out_last;
  logic [1:0]     cur_ch;

  logic           mode3, out_ready3;
  logic [1:0]     sel3;
  logic [3*W-1:0] in_data3;
  logic [2:0]     in_valid3, in_last3, in_ready3;
  logic [W-1:0]   out_data3;
  logic           out_valid3, out_last3;
  logic [1:0]     cur_ch3;

  mux_stream #(.WIDTH(W), .N(N)) u_dut (
    .clk(clk), .rst(rst), .mode(mode), .sel(sel), .in_data(in_data),
    .in_valid(in_valid), .in_last(in_last), .in_ready(in_ready),
    .out_data(out_data), .out_valid(out_valid), .out_last(out_last),
    .out_ready(out_ready), .cur_ch(cur_ch)
  );

  mux_stream #(.WIDTH(W), .N(3)) u_dut3 (
    .clk(clk), .rst(rst), .mode(mode3), .sel(sel3), .in_data(in_data3),
    .in_valid(in_valid3), .in_last(in_last3), .in_ready(in_ready3),
    .out_data(out_data3), .out_valid(out_valid3), .out_last(out_last3),
    .out_ready(out_ready3), .cur_ch(cur_ch3)
  );

  int total = 0;
  int bad   = 0;

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    total++;
    if (got !== exp) begin
      bad++;
      $display("FAIL %s got=%0h exp=%0h at %0t", tag, got, exp, $time);
    end
  endtask

  // stimulus policy
  int p_mode, p_sel, p_rdy, p_gen, p_valid, p_rst, fixed_len;

  // per-channel packet sources
  bit         s_has  [N];
  logic [7:0] s_data [N];
  bit         s_last [N];
  int         s_beat [N];
  int         s_len  [N];
  int         s_pkt  [N];

  // reference model: lock is -1 when no packet is owned
  int         m_lock, m_cur;
  bit         m_ov, m_ol;
  logic [7:0] m_od;

  task automatic reset_sources();
    for (int c = 0; c < N; c++) begin
      s_has[c]  = 1'b0;
      s_beat[c] = 0;
    end
  endtask

  task automatic cycle();
    int         nlock, ncur, s, acc_ch;
    bit         nov, nol, acc;
    logic [7:0] nod;
    logic [N-1:0] exp_rdy;
    @(negedge clk);
    check("out_valid", out_valid, m_ov);
    check("out_data", out_data, m_od);
    check("out_last", out_last, m_ol);
    check("cur_ch", cur_ch, m_cur);

    rst       = (p_rst > 0) && (($urandom % 100) < p_rst);
    mode      = (p_mode == 2) ? 1'($urandom) : p_mode[0];
    sel       = (p_sel < 0) ? 2'($urandom) : p_sel[1:0];
    out_ready = ($urandom % 100) < p_rdy;
    for (int c = 0; c < N; c++) begin
      if (!s_has[c] && (($urandom % 100) < p_gen)) begin
        if (s_beat[c] == 0) s_len[c] = (fixed_len > 0) ? fixed_len : $urandom_range(1, 4);
        s_has[c]  = 1'b1;
        s_data[c] = {c[1:0], s_pkt[c][1:0], s_beat[c][3:0]};
        s_last[c] = (s_beat[c] == s_len[c] - 1);
      end
      in_valid[c]       = s_has[c] && (($urandom % 100) < p_valid);
      in_data[c*W +: W] = s_has[c] ? s_data[c] : 8'($urandom);
      in_last[c]        = s_has[c] ? s_last[c] : 1'($urandom);
    end
    #1;
    exp_rdy = '0;
    if (m_lock >= 0 && (!m_ov || out_ready)) exp_rdy[m_lock] = 1'b1;
    check("in_ready", in_ready, exp_rdy);

    nlock = m_lock; ncur = m_cur; nov = m_ov; nod = m_od; nol = m_ol;
    acc = 1'b0; acc_ch = m_lock;
    if (rst) begin
      nlock = -1; ncur = N - 1; nov = 1'b0; nod = '0; nol = 1'b0;
    end else begin
      if (m_lock < 0) begin
        if (mode == 1'b0) begin
          s = sel;
          if (s < N && in_valid[s]) begin nlock = s; ncur = s; end
        end else begin
          for (int i = 1; i <= N; i++) begin
            int c = (m_cur + i) % N;
            if (nlock < 0 && in_valid[c]) begin nlock = c; ncur = c; end
          end
        end
      end else if (in_valid[m_lock] && (!m_ov || out_ready)) begin
        acc = 1'b1; nov = 1'b1; nod = s_data[m_lock]; nol = s_last[m_lock];
        if (nol) nlock = -1;
      end
      if (!acc && out_ready) nov = 1'b0;
    end

    @(posedge clk);
    m_lock = nlock; m_cur = ncur; m_ov = nov; m_od = nod; m_ol = nol;
    if (rst) reset_sources();
    else if (acc) begin
      s_has[acc_ch] = 1'b0;
      if (s_last[acc_ch]) begin
        s_beat[acc_ch] = 0;
        s_pkt[acc_ch]++;
      end else begin
        s_beat[acc_ch]++;
      end
    end
  endtask

  task automatic phase(input int n, input int md, input int sl, input int rdy,
                       input int gen, input int vld, input int rs, input int fl);
    p_mode = md; p_sel = sl; p_rdy = rdy; p_gen = gen; p_valid = vld; p_rst = rs; fixed_len = fl;
    repeat (n) cycle();
  endtask

  initial begin
    rst = 1'b1; mode = 1'b1; sel = '0; out_ready = 1'b1;
    in_data = '0; in_valid = '1; in_last = '0;
    mode3 = 1'b0; sel3 = '0; out_ready3 = 1'b1; in_data3 = '0; in_valid3 = '0; in_last3 = '0;
    for (int c = 0; c < N; c++) s_pkt[c] = 0;
    reset_sources();
    m_lock = -1; m_cur = N - 1; m_ov = 1'b0; m_od = '0; m_ol = 1'b0;
    repeat (2) @(posedge clk);

    // reset held with every channel presenting a beat
    phase(3, 1, 0, 100, 100, 100, 100, 0);
    #1;
    check("rst_out_valid", out_valid, 0);
    check("rst_out_data", out_data, 0);
    check("rst_out_last", out_last, 0);
    check("rst_in_ready", in_ready, 0);
    check("rst_cur_ch", cur_ch, N - 1);

    // first arbitration after reset favours channel 0
    phase(1, 1, 0, 100, 100, 100, 0, 0);
    #1;
    check("first_grant", cur_ch, 0);

    phase(40, 1, 0, 100, 100, 100, 0, 2);
    phase(150, 0, -1, 100, 60, 80, 0, 0);
    phase(300, 2, -1, 50, 70, 80, 0, 0);
    phase(300, 2, -1, 70, 70, 90, 3, 0);
    phase(200, 1, 0, 80, 50, 70, 0, 0);

    // N=3 instance: sel beyond the last channel never grants
    @(negedge clk);
    rst = 1'b0; in_valid = '0;
    mode3 = 1'b0; sel3 = 2'd3; in_valid3 = 3'b111; in_data3 = 24'h302010; out_ready3 = 1'b1;
    for (int i = 0; i < 10; i++) begin
      @(negedge clk);
      check("n3_in_ready", in_ready3, 0);
      check("n3_out_valid", out_valid3, 0);
    end
    mode3 = 1'b1;
    @(negedge clk);
    check("n3_rr_cur", cur_ch3, 0);
    check("n3_rr_ready", in_ready3, 3'b001);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
